// File: rtl/io_pkg.sv
// io_pkg: shared constants for the board I/O responder.
//   Register word indices for the memory-mapped I/O window and the
//   bit position of each button inside the button registers.
package io_pkg;

  localparam logic [2:0] IO_SW        = 3'd0;
  localparam logic [2:0] IO_BTN_LEVEL = 3'd1;
  localparam logic [2:0] IO_BTN_EVENT = 3'd2;
  localparam logic [2:0] IO_LED       = 3'd3;
  localparam logic [2:0] IO_IRQ_EN    = 3'd4;

  localparam int BTN_U   = 0;
  localparam int BTN_D   = 1;
  localparam int BTN_L   = 2;
  localparam int BTN_R   = 3;
  localparam int NUM_BTN = 4;

endpackage

// File: rtl/btn_debounce.sv
// btn_debounce: one raw button -> synchronized, debounced level plus a
// one-cycle rise pulse.
//   clk, reset  : clock, async active-low reset
//   btn_i       : raw button, asynchronous to clk
//   level_o     : debounced level
//   rise_o      : high for the cycle before level_o goes 0->1 (only once
//                 the button has been seen released since reset)
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CNT_W           = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_i,
  output logic level_o,
  output logic rise_o
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             s1_q, s2_q;
  logic [1:0]       vld_q;     // sync pipeline has real samples in it
  logic             armed_q;   // button seen released since reset
  logic [CNT_W-1:0] cnt_q;
  logic             stable_q;
  logic             mismatch, settle;

  assign mismatch = (s2_q != stable_q);
  assign settle   = mismatch && (cnt_q == LAST);
  // A button held through reset release settles high without an event;
  // it must be released and pressed again to report a press.
  assign rise_o   = settle && s2_q && armed_q;
  assign level_o  = stable_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1_q     <= 1'b0;
      s2_q     <= 1'b0;
      vld_q    <= '0;
      armed_q  <= 1'b0;
      cnt_q    <= '0;
      stable_q <= 1'b0;
    end else begin
      s1_q  <= btn_i;
      s2_q  <= s1_q;
      vld_q <= {vld_q[0], 1'b1};
      if (vld_q[1] && !s2_q) armed_q <= 1'b1;
      if (!mismatch || settle) cnt_q <= '0;
      else                     cnt_q <= cnt_q + CNT_W'(1);
      if (settle) stable_q <= s2_q;
    end
  end

endmodule

// File: rtl/io_input_ctrl.sv
// io_input_ctrl: memory-mapped board I/O responder.
//   clk, reset         : clock, async active-low reset
//   switches           : raw switches (async), synchronized into SW
//   btn_u/d/l/r        : raw buttons (async), debounced, presses latched
//   io_addr/rd/we/wdata: CPU register access (word index 0..7)
//   io_rdata           : registered read data, valid cycle after io_rd
//   leds               : LED register
//   irq                : registered |(event & irq_en)
module io_input_ctrl
  import io_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CNT_W           = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] switches,
  input  logic        btn_u,
  input  logic        btn_d,
  input  logic        btn_l,
  input  logic        btn_r,
  input  logic [2:0]  io_addr,
  input  logic        io_rd,
  input  logic        io_we,
  input  logic [31:0] io_wdata,
  output logic [31:0] io_rdata,
  output logic [15:0] leds,
  output logic        irq
);

  logic [15:0]        sw_s1_q, sw_s2_q;
  logic [NUM_BTN-1:0] btn_raw, level, rise;
  logic [NUM_BTN-1:0] event_q, event_d, en_q, clr;
  logic [15:0]        led_q;
  logic [31:0]        rdata_q, rd_val;
  logic               irq_q;
  logic               unused_wdata;

  assign unused_wdata = ^io_wdata[31:16];

  always_comb begin
    btn_raw        = '0;
    btn_raw[BTN_U] = btn_u;
    btn_raw[BTN_D] = btn_d;
    btn_raw[BTN_L] = btn_l;
    btn_raw[BTN_R] = btn_r;
  end

  for (genvar g = 0; g < NUM_BTN; g++) begin : g_btn
    btn_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .CNT_W          (CNT_W)
    ) u_db (
      .clk    (clk),
      .reset  (reset),
      .btn_i  (btn_raw[g]),
      .level_o(level[g]),
      .rise_o (rise[g])
    );
  end

  // Read mux always sees pre-write state, so rd+we returns the old value.
  always_comb begin
    rd_val = '0;
    case (io_addr)
      IO_SW:        rd_val = {16'b0, sw_s2_q};
      IO_BTN_LEVEL: rd_val = {28'b0, level};
      IO_BTN_EVENT: rd_val = {28'b0, event_q};
      IO_LED:       rd_val = {16'b0, led_q};
      IO_IRQ_EN:    rd_val = {28'b0, en_q};
      default:      rd_val = '0;
    endcase
  end

  // Clear-on-read plus W1C; a rise in the same cycle wins over the clear.
  always_comb begin
    clr = '0;
    if (io_addr == IO_BTN_EVENT) begin
      if (io_rd) clr = clr | event_q;
      if (io_we) clr = clr | io_wdata[NUM_BTN-1:0];
    end
    event_d = (event_q & ~clr) | rise;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sw_s1_q <= '0;
      sw_s2_q <= '0;
      event_q <= '0;
      en_q    <= '0;
      led_q   <= '0;
      rdata_q <= '0;
      irq_q   <= 1'b0;
    end else begin
      sw_s1_q <= switches;
      sw_s2_q <= sw_s1_q;
      event_q <= event_d;
      irq_q   <= |(event_q & en_q);
      if (io_rd) rdata_q <= rd_val;
      if (io_we) begin
        if (io_addr == IO_LED)    led_q <= io_wdata[15:0];
        if (io_addr == IO_IRQ_EN) en_q  <= io_wdata[NUM_BTN-1:0];
      end
    end
  end

  assign io_rdata = rdata_q;
  assign leds     = led_q;
  assign irq      = irq_q;

endmodule

// File: tb/tb_io_input_ctrl.sv
module tb_io_input_ctrl;

  localparam int D = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] switches = '0;
  logic        btn_u = 1'b0, btn_d = 1'b0, btn_l = 1'b0, btn_r = 1'b0;
  logic [2:0]  io_addr = '0;
  logic        io_rd = 1'b0, io_we = 1'b0;
  logic [31:0] io_wdata = '0;
  logic [31:0] io_rdata;
  logic [15:0] leds;
  logic        irq;

  always #5 clk = ~clk;

  io_input_ctrl #(.DEBOUNCE_CYCLES(D), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .switches(switches),
    .btn_u(btn_u), .btn_d(btn_d), .btn_l(btn_l), .btn_r(btn_r),
    .io_addr(io_addr), .io_rd(io_rd), .io_we(io_we), .io_wdata(io_wdata),
    .io_rdata(io_rdata), .leds(leds), .irq(irq)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // Debounce is modelled as a window: the level flips once the last D
  // synchronized samples all disagree with it.
  logic [15:0]  m_sw [2];
  logic [3:0]   m_b1, m_b2;
  logic [D-1:0] m_hist [4];
  logic [3:0]   m_lvl, m_arm, m_ev, m_en;
  logic [15:0]  m_led;
  logic [31:0]  m_rd;
  logic         m_irq;
  int           m_edges;

  task automatic model_reset();
    m_sw[0] = '0; m_sw[1] = '0; m_b1 = '0; m_b2 = '0;
    for (int b = 0; b < 4; b++) m_hist[b] = '0;
    m_lvl = '0; m_arm = '0; m_ev = '0; m_en = '0;
    m_led = '0; m_rd = '0; m_irq = 1'b0; m_edges = 0;
  endtask

  task automatic model_step();
    logic [3:0]   raw, rise, lvl_n, arm_n, clr;
    logic [D-1:0] win;
    logic [31:0]  val;
    raw   = {btn_r, btn_l, btn_d, btn_u};
    rise  = '0;
    lvl_n = m_lvl;
    arm_n = m_arm;
    for (int b = 0; b < 4; b++) begin
      win = {m_hist[b][D-2:0], m_b2[b]};
      m_hist[b] = win;
      if (win == {D{~m_lvl[b]}}) begin
        lvl_n[b] = ~m_lvl[b];
        if (!m_lvl[b] && m_arm[b]) rise[b] = 1'b1;
      end
      if (m_edges >= 2 && !m_b2[b]) arm_n[b] = 1'b1;
    end
    case (io_addr)
      3'd0:    val = {16'b0, m_sw[1]};
      3'd1:    val = {28'b0, m_lvl};
      3'd2:    val = {28'b0, m_ev};
      3'd3:    val = {16'b0, m_led};
      3'd4:    val = {28'b0, m_en};
      default: val = 32'h0;
    endcase
    clr = '0;
    if (io_addr == 3'd2 && io_rd) clr = clr | m_ev;
    if (io_addr == 3'd2 && io_we) clr = clr | io_wdata[3:0];
    m_irq = |(m_ev & m_en);
    m_ev  = (m_ev & ~clr) | rise;
    if (io_rd) m_rd = val;
    if (io_we && io_addr == 3'd3) m_led = io_wdata[15:0];
    if (io_we && io_addr == 3'd4) m_en  = io_wdata[3:0];
    m_lvl = lvl_n;
    m_arm = arm_n;
    m_sw[1] = m_sw[0]; m_sw[0] = switches;
    m_b2 = m_b1; m_b1 = raw;
    m_edges++;
  endtask

  // One clock: advance model, cross the edge, compare at the falling edge.
  task automatic tick();
    if (reset) model_step(); else model_reset();
    @(posedge clk);
    @(negedge clk);
    chk("model rdata", io_rdata, m_rd);
    chk("model leds", {16'b0, leds}, {16'b0, m_led});
    chk("model irq", {31'b0, irq}, {31'b0, m_irq});
  endtask

  task automatic wr_reg(input logic [2:0] a, input logic [31:0] d);
    io_we = 1'b1; io_addr = a; io_wdata = d;
    tick();
    io_we = 1'b0;
  endtask

  task automatic rd_reg(input logic [2:0] a, output logic [31:0] d);
    io_rd = 1'b1; io_addr = a;
    tick();
    io_rd = 1'b0;
    d = io_rdata;
  endtask

  typedef struct {
    logic [2:0]  a;
    logic        rd;
    logic        we;
    logic [31:0] wd;
    logic [31:0] exp_rd;
    logic [15:0] exp_led;
  } vec_t;

  vec_t        tbl [13];
  logic [31:0] r;

  initial begin
    model_reset();
    #1 reset = 1'b0;
    #11;
    chk("reset leds", {16'b0, leds}, 32'h0);
    chk("reset rdata", io_rdata, 32'h0);
    chk("reset irq", {31'b0, irq}, 32'h0);
    @(negedge clk);
    reset = 1'b1;

    // switch synchronizer latency
    switches = 16'h0003; io_rd = 1'b1; io_addr = 3'd0;
    tick(); chk("sw edge1", io_rdata, 32'h0);
    tick(); chk("sw edge2", io_rdata, 32'h0);
    tick(); chk("sw edge3", io_rdata, 32'h3);
    io_rd = 1'b0;

    // register file table
    tbl[0]  = '{3'd3, 1'b0, 1'b1, 32'hABCD1234, 32'h3,    16'h1234};
    tbl[1]  = '{3'd3, 1'b1, 1'b0, 32'h0,        32'h1234, 16'h1234};
    tbl[2]  = '{3'd6, 1'b0, 1'b1, 32'hFFFFFFFF, 32'h1234, 16'h1234};
    tbl[3]  = '{3'd6, 1'b1, 1'b0, 32'h0,        32'h0,    16'h1234};
    tbl[4]  = '{3'd4, 1'b0, 1'b1, 32'hFFFFFFF5, 32'h0,    16'h1234};
    tbl[5]  = '{3'd4, 1'b1, 1'b0, 32'h0,        32'h5,    16'h1234};
    tbl[6]  = '{3'd0, 1'b1, 1'b1, 32'h0000FFFF, 32'h3,    16'h1234};
    tbl[7]  = '{3'd3, 1'b1, 1'b1, 32'h00005555, 32'h1234, 16'h5555};
    tbl[8]  = '{3'd3, 1'b1, 1'b0, 32'h0,        32'h5555, 16'h5555};
    tbl[9]  = '{3'd1, 1'b1, 1'b1, 32'h0000000F, 32'h0,    16'h5555};
    tbl[10] = '{3'd5, 1'b1, 1'b0, 32'h0,        32'h0,    16'h5555};
    tbl[11] = '{3'd7, 1'b1, 1'b1, 32'h12345678, 32'h0,    16'h5555};
    tbl[12] = '{3'd4, 1'b0, 1'b1, 32'h0,        32'h0,    16'h5555};
    for (int i = 0; i < 13; i++) begin
      io_addr = tbl[i].a; io_rd = tbl[i].rd; io_we = tbl[i].we; io_wdata = tbl[i].wd;
      tick();
      chk($sformatf("tbl%0d rdata", i), io_rdata, tbl[i].exp_rd);
      chk($sformatf("tbl%0d leds", i), {16'b0, leds}, {16'b0, tbl[i].exp_led});
    end
    io_rd = 1'b0; io_we = 1'b0;

    // btn_u level latency, then event clear-on-read
    io_rd = 1'b1; io_addr = 3'd1; btn_u = 1'b1;
    for (int k = 1; k <= 7; k++) begin
      tick();
      chk($sformatf("btn_u level edge%0d", k), io_rdata, (k == 7) ? 32'h1 : 32'h0);
    end
    io_rd = 1'b0;
    repeat (3) tick();
    btn_u = 1'b0;
    repeat (10) tick();
    rd_reg(3'd2, r); chk("btn_u event", r, 32'h1);
    rd_reg(3'd2, r); chk("btn_u event cleared", r, 32'h0);

    // btn_d glitch rejected, minimum pulse accepted
    btn_d = 1'b1; repeat (3) tick(); btn_d = 1'b0;
    repeat (10) tick();
    rd_reg(3'd1, r); chk("glitch level", r, 32'h0);
    rd_reg(3'd2, r); chk("glitch event", r, 32'h0);
    btn_d = 1'b1; repeat (4) tick(); btn_d = 1'b0;
    repeat (10) tick();
    rd_reg(3'd2, r); chk("min pulse event", r, 32'h2);

    // irq and W1C
    wr_reg(3'd4, 32'h4);
    btn_l = 1'b1; repeat (8) tick();
    chk("irq after btn_l", {31'b0, irq}, 32'h1);
    btn_r = 1'b1; repeat (8) tick();
    wr_reg(3'd2, 32'h4);
    chk("irq lags w1c", {31'b0, irq}, 32'h1);
    tick();
    chk("irq dropped", {31'b0, irq}, 32'h0);
    rd_reg(3'd2, r); chk("event bit3 kept", r, 32'h8);
    btn_l = 1'b0; btn_r = 1'b0;
    repeat (10) tick();

    // set/clear collision
    btn_u = 1'b1; repeat (5) tick();
    rd_reg(3'd2, r); chk("collision read", r, 32'h0);
    rd_reg(3'd2, r); chk("collision survivor", r, 32'h1);
    btn_u = 1'b0; repeat (10) tick();

    // reset mid-debounce with event pending
    wr_reg(3'd3, 32'h00FF);
    wr_reg(3'd4, 32'hF);
    btn_r = 1'b1; repeat (8) tick();
    chk("pre-reset irq", {31'b0, irq}, 32'h1);
    btn_d = 1'b1; repeat (4) tick();
    #2 reset = 1'b0;
    model_reset();
    #1;
    chk("async reset leds", {16'b0, leds}, 32'h0);
    chk("async reset irq", {31'b0, irq}, 32'h0);
    chk("async reset rdata", io_rdata, 32'h0);
    @(negedge clk);
    repeat (2) tick();
    reset = 1'b1;
    repeat (12) tick();
    rd_reg(3'd1, r); chk("held level", r, 32'hA);
    rd_reg(3'd2, r); chk("held no event", r, 32'h0);
    btn_d = 1'b0; btn_r = 1'b0; repeat (10) tick();
    btn_d = 1'b1; repeat (10) tick();
    rd_reg(3'd2, r); chk("re-press event", r, 32'h2);
    btn_d = 1'b0; repeat (10) tick();

    // randomized traffic against the model
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 9) == 0) btn_u = ~btn_u;
      if ($urandom_range(0, 9) == 0) btn_d = ~btn_d;
      if ($urandom_range(0, 14) == 0) btn_l = ~btn_l;
      if ($urandom_range(0, 29) == 0) btn_r = ~btn_r;
      if ($urandom_range(0, 15) == 0) switches = 16'($urandom);
      io_rd    = ($urandom_range(0, 2) == 0);
      io_we    = ($urandom_range(0, 5) == 0);
      io_addr  = 3'($urandom_range(0, 7));
      io_wdata = $urandom;
      tick();
    end
    io_rd = 1'b0; io_we = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
